// File: rtl/dw_accum_dx_pkg.sv
// Shared types and saturation constants for the duplex saturating accumulator.
package dw_accum_dx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic       dplx;
    logic       tc;
    logic       sat;
    logic [7:0] acc_len;
  } mode_t;

  localparam int MAX_LANE_W = 64;

  // Largest representable lane value: 0 followed by ones when signed, all ones otherwise.
  function automatic logic [MAX_LANE_W-1:0] lane_max(input int w, input logic tc);
    logic [MAX_LANE_W-1:0] ones;
    ones = '1;
    lane_max = tc ? (ones >> (MAX_LANE_W + 1 - w)) : (ones >> (MAX_LANE_W - w));
  endfunction

  function automatic logic [MAX_LANE_W-1:0] lane_min(input int w, input logic tc);
    lane_min = tc ? (MAX_LANE_W'(1) << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/dw_accum_dx_if.sv
// Sample-in / total-out handshake bundle for dw_accum_dx.
interface dw_accum_dx_if #(
  parameter int width = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] acc_out;
  logic             ovf1;
  logic             ovf2;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, acc_out, ovf1, ovf2
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, acc_out, ovf1, ovf2
  );
endinterface

// File: rtl/dw_accum_lane.sv
// Combinational lane adder: add with carry-in, overflow detect, optional clamp.
module dw_accum_lane
  import dw_accum_dx_pkg::*;
#(
  parameter int lane_w = 4
) (
  input  logic [lane_w-1:0] a,
  input  logic [lane_w-1:0] b,
  input  logic              cin,
  input  logic              tc,
  input  logic              sat,
  output logic [lane_w-1:0] res,
  output logic              ovf
);
  localparam logic [MAX_LANE_W-1:0] MAX_U = lane_max(lane_w, 1'b0);
  localparam logic [MAX_LANE_W-1:0] MAX_S = lane_max(lane_w, 1'b1);
  localparam logic [MAX_LANE_W-1:0] MIN_S = lane_min(lane_w, 1'b1);

  logic [lane_w:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{lane_w{1'b0}}, cin};
    // Unsigned overflow is the raw carry, which also serves as the chain carry.
    if (tc) ovf = (a[lane_w-1] == b[lane_w-1]) && (sum[lane_w-1] != a[lane_w-1]);
    else    ovf = sum[lane_w];
    res = sum[lane_w-1:0];
    if (sat && ovf) begin
      if (!tc)              res = MAX_U[lane_w-1:0];
      else if (a[lane_w-1]) res = MIN_S[lane_w-1:0];
      else                  res = MAX_S[lane_w-1:0];
    end
  end
endmodule

// File: rtl/dw_accum_dx.sv
// Duplex-capable saturating block accumulator with valid/ready result port.
// Optional per-lane averaging shift enabled by defining DW_ACCUM_DX_AVG_EN.
module dw_accum_dx
  import dw_accum_dx_pkg::*;
#(
  parameter  int width    = 8,
  parameter  int p1_width = 4,
  localparam int p2_width = width - p1_width
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       dplx,
  input  logic       tc,
  input  logic       sat,
  input  logic [7:0] acc_len,
`ifdef DW_ACCUM_DX_AVG_EN
  input  logic [3:0] shamt,
`endif
  dw_accum_dx_if.slave bus
);
  state_e           state_q, state_d;
  mode_t            mode_q, mode_d, cur_mode;
  logic [7:0]       cnt_q, cnt_d, len_eff;
  logic [width-1:0] acc_q, acc_d, sum, nxt, fin;
  logic             ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  logic             out_valid_q, out_valid_d;
  logic             hs;

  logic [p1_width-1:0] res_lo, lo_fix;
  logic [p2_width-1:0] res_hi;
  logic                ovf_lo, ovf_hi, lo_tc, lo_sat, hi_cin;

`ifdef DW_ACCUM_DX_AVG_EN
  logic [3:0] shamt_q, shamt_d, cur_shamt;

  // Per-lane right shift; bits shifted in from above the lane MSB are sign or zero.
  function automatic logic [width-1:0] avg_shift(input logic [width-1:0] v, input logic dp,
                                                 input logic sg, input logic [3:0] sh);
    int   base, w, idx;
    logic s;
    avg_shift = '0;
    for (int i = 0; i < width; i++) begin
      if (dp && i >= p1_width) begin base = p1_width; w = p2_width; end
      else if (dp)             begin base = 0;        w = p1_width; end
      else                     begin base = 0;        w = width;    end
      s   = sg & v[base + w - 1];
      idx = i + int'(sh);
      avg_shift[i] = (idx < base + w) ? v[idx] : s;
    end
  endfunction
`endif

  // Mode inputs only matter when a block starts; afterwards the latched copy rules.
  assign cur_mode = (state_q == IDLE) ? {dplx, tc, sat, acc_len} : mode_q;
  assign len_eff  = (cur_mode.acc_len == 8'd0) ? 8'd1 : cur_mode.acc_len;
  assign hs       = bus.in_valid && bus.in_ready;

  // In full-width mode the low lane is a plain unsigned wrap adder whose carry feeds the high lane.
  assign lo_tc  = cur_mode.dplx & cur_mode.tc;
  assign lo_sat = cur_mode.dplx & cur_mode.sat;
  assign hi_cin = ~cur_mode.dplx & ovf_lo;

  dw_accum_lane #(.lane_w(p1_width)) u_lane_lo (
    .a(acc_q[p1_width-1:0]), .b(bus.din[p1_width-1:0]), .cin(1'b0),
    .tc(lo_tc), .sat(lo_sat), .res(res_lo), .ovf(ovf_lo)
  );

  dw_accum_lane #(.lane_w(p2_width)) u_lane_hi (
    .a(acc_q[width-1:p1_width]), .b(bus.din[width-1:p1_width]), .cin(hi_cin),
    .tc(cur_mode.tc), .sat(cur_mode.sat), .res(res_hi), .ovf(ovf_hi)
  );

  always_comb begin
    lo_fix = res_lo;
    // A saturated full word clamps the low bits too: ones, except zeros for signed negative.
    if (!cur_mode.dplx && cur_mode.sat && ovf_hi)
      lo_fix = {p1_width{cur_mode.tc ? ~res_hi[p2_width-1] : 1'b1}};
    sum = {res_hi, lo_fix};
    nxt = (state_q == IDLE) ? bus.din : sum;
`ifdef DW_ACCUM_DX_AVG_EN
    cur_shamt = (state_q == IDLE) ? shamt : shamt_q;
    fin       = avg_shift(nxt, cur_mode.dplx, cur_mode.tc, cur_shamt);
`else
    fin       = nxt;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf1_d      = ovf1_q;
    ovf2_d      = ovf2_q;
    out_valid_d = out_valid_q;
`ifdef DW_ACCUM_DX_AVG_EN
    shamt_d     = shamt_q;
`endif
    case (state_q)
      IDLE: if (hs) begin
        mode_d = cur_mode;
        cnt_d  = 8'd1;
        acc_d  = nxt;
        ovf1_d = 1'b0;
        ovf2_d = 1'b0;
`ifdef DW_ACCUM_DX_AVG_EN
        shamt_d = shamt;
`endif
        if (len_eff == 8'd1) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          acc_d       = fin;
        end else begin
          state_d = ACC;
        end
      end
      ACC: if (hs) begin
        cnt_d  = cnt_q + 8'd1;
        acc_d  = nxt;
        ovf1_d = ovf1_q | (cur_mode.dplx & ovf_lo);
        ovf2_d = ovf2_q | ovf_hi;
        if (cnt_d == len_eff) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          acc_d       = fin;
        end
      end
      HOLD: if (bus.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (clr) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = 8'd0;
      acc_d       = '0;
      ovf1_d      = 1'b0;
      ovf2_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      ovf1_q      <= 1'b0;
      ovf2_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef DW_ACCUM_DX_AVG_EN
      shamt_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf1_q      <= ovf1_d;
      ovf2_q      <= ovf2_d;
      out_valid_q <= out_valid_d;
`ifdef DW_ACCUM_DX_AVG_EN
      shamt_q     <= shamt_d;
`endif
    end
  end

  assign bus.in_ready  = rst_n && (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.ovf1      = ovf1_q;
  assign bus.ovf2      = ovf2_q;
endmodule

// File: tb/tb_dw_accum_dx.sv
// Bench for dw_accum_dx: vector table, directed multi-cycle sequences, random blocks vs. model.
module tb_dw_accum_dx;
  logic       clk;
  logic       rst_n, clr, dplx, tc, sat;
  logic [7:0] acc_len;
`ifdef DW_ACCUM_DX_AVG_EN
  logic [3:0] shamt;
`endif
  int checks   = 0;
  int failures = 0;

  dw_accum_dx_if #(.width(8)) bus ();

  dw_accum_dx #(.width(8), .p1_width(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dplx(dplx), .tc(tc), .sat(sat), .acc_len(acc_len),
`ifdef DW_ACCUM_DX_AVG_EN
    .shamt(shamt),
`endif
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       nm;
    logic        dp, t, st;
    logic [7:0]  len;
    int          n;
    logic [31:0] d;
    logic [7:0]  ea;
    logic        e1, e2;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic dp, t, st, input logic [7:0] len,
                         input int n, input logic [31:0] d, input logic [7:0] ea, input logic e1, e2);
    vec_t v;
    v.nm = nm; v.dp = dp; v.t = t; v.st = st; v.len = len; v.n = n;
    v.d = d; v.ea = ea; v.e1 = e1; v.e2 = e2;
    vq.push_back(v);
  endtask

  // Lane value as an integer: signed or unsigned reading of the bit field.
  function automatic longint lane_get(input logic [7:0] wd, input int off, input int w, input logic t);
    longint u;
    u = longint'(wd >> off) & ((longint'(1) << w) - 1);
    if (t && u >= (longint'(1) << (w - 1))) u = u - (longint'(1) << w);
    return u;
  endfunction

  task automatic model(input logic [7:0] s[$], input logic dp, t, st,
                       output logic [7:0] acc, output logic o1, o2);
    acc = 8'h00; o1 = 1'b0; o2 = 1'b0;
    for (int l = 0; l < (dp ? 2 : 1); l++) begin
      int     off, w;
      longint a, lo, hi;
      logic   ov;
      off = (dp && l == 1) ? 4 : 0;
      w   = dp ? 4 : 8;
      hi  = t ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
      lo  = t ? -(longint'(1) << (w - 1)) : 0;
      a   = lane_get(s[0], off, w, t);
      ov  = 1'b0;
      for (int i = 1; i < s.size(); i++) begin
        a = a + lane_get(s[i], off, w, t);
        if (a > hi) begin
          ov = 1'b1;
          a  = st ? hi : a - (longint'(1) << w);
        end else if (a < lo) begin
          ov = 1'b1;
          a  = st ? lo : a + (longint'(1) << w);
        end
      end
      acc = acc | 8'((a & ((longint'(1) << w) - 1)) << off);
      if (dp && l == 0) o1 = ov;
      else              o2 = ov;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sample is accepted.
  task automatic send(input logic [7:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.din      = d;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input string nm, input logic dp, t, st, input logic [7:0] len,
                           input logic [7:0] s[$], input logic [7:0] ea, input logic e1, e2,
                           input bit scr, input int stall);
    dplx = dp; tc = t; sat = st; acc_len = len;
    for (int i = 0; i < s.size(); i++) begin
      if (i == s.size() - 1) chk({nm, ".early_valid"}, 32'(bus.out_valid), 32'd0);
      send(s[i]);
      if (scr && i == 0) begin
        dplx = 1'($urandom); tc = 1'($urandom); sat = 1'($urandom);
        acc_len = 8'($urandom);
      end
      if (scr && i < s.size() - 1 && $urandom_range(0, 1) == 1) @(negedge clk);
    end
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".in_ready_hold"}, 32'(bus.in_ready), 32'd0);
    chk({nm, ".acc_out"}, 32'(bus.acc_out), 32'(ea));
    chk({nm, ".ovf1"}, 32'(bus.ovf1), 32'(e1));
    chk({nm, ".ovf2"}, 32'(bus.ovf2), 32'(e2));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({nm, ".stall_acc"}, 32'(bus.acc_out), 32'(ea));
      chk({nm, ".stall_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] ea;
    logic       e1, e2;

    rst_n = 1'b0; clr = 1'b0; dplx = 1'b0; tc = 1'b0; sat = 1'b0; acc_len = 8'd0;
`ifdef DW_ACCUM_DX_AVG_EN
    shamt = 4'd0;
`endif
    bus.in_valid = 1'b0; bus.din = 8'h00; bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.acc_out", 32'(bus.acc_out), 32'd0);
    chk("rst.ovf1", 32'(bus.ovf1), 32'd0);
    chk("rst.ovf2", 32'(bus.ovf2), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    add_vec("u_sat_full",      0, 0, 1, 8'd3, 3, 32'h00207080, 8'hFF, 0, 1);
    add_vec("s_sat_dplx",      1, 1, 1, 8'd2, 2, 32'h00001177, 8'h77, 1, 1);
    add_vec("s_wrap_dplx",     1, 1, 0, 8'd2, 2, 32'h00008888, 8'h00, 1, 1);
    add_vec("s_sat_neg",       0, 1, 1, 8'd2, 2, 32'h0000FF80, 8'h80, 0, 1);
    add_vec("s_sat_pos",       0, 1, 1, 8'd2, 2, 32'h0000017F, 8'h7F, 0, 1);
    add_vec("u_wrap_nocarry",  1, 0, 0, 8'd2, 2, 32'h0000010F, 8'h00, 1, 0);
    add_vec("u_wrap_carry",    0, 0, 0, 8'd2, 2, 32'h0000010F, 8'h10, 0, 0);
    add_vec("u_sat_sticky",    1, 0, 1, 8'd3, 3, 32'h00019C9C, 8'hFF, 1, 1);
    add_vec("u_wrap_sticky",   0, 0, 0, 8'd3, 3, 32'h000120F0, 8'h11, 0, 1);
    add_vec("len0",            0, 0, 0, 8'd0, 1, 32'h0000005A, 8'h5A, 0, 0);
    add_vec("s_sat_dplx_neg",  1, 1, 1, 8'd2, 2, 32'h00008888, 8'h88, 1, 1);
    add_vec("s_sat_full_neg",  0, 1, 1, 8'd2, 2, 32'h00008888, 8'h80, 0, 1);
    add_vec("len1_dplx",       1, 1, 1, 8'd1, 1, 32'h000000A5, 8'hA5, 0, 0);
    add_vec("u_sat_noovf",     0, 0, 1, 8'd4, 4, 32'h04030201, 8'h0A, 0, 0);

    foreach (vq[j]) begin
      s.delete();
      for (int i = 0; i < vq[j].n; i++) s.push_back(vq[j].d[i*8 +: 8]);
      run_block(vq[j].nm, vq[j].dp, vq[j].t, vq[j].st, vq[j].len, s, vq[j].ea, vq[j].e1, vq[j].e2, 1'b0, 0);
    end

    // Output held with out_ready low; upstream holds a new sample across HOLD
    dplx = 1'b0; tc = 1'b0; sat = 1'b0; acc_len = 8'd0;
    bus.in_valid = 1'b1; bus.din = 8'h5A;
    @(negedge clk);
    bus.din = 8'h33;
    for (int k = 0; k < 5; k++) begin
      chk("hold.valid", 32'(bus.out_valid), 32'd1);
      chk("hold.acc", 32'(bus.acc_out), 32'h5A);
      chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold.release_valid", 32'(bus.out_valid), 32'd0);
    chk("hold.release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold.next_valid", 32'(bus.out_valid), 32'd1);
    chk("hold.next_acc", 32'(bus.acc_out), 32'h33);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // clr mid-block with a simultaneous sample, then a clean block, then reset in HOLD
    dplx = 1'b0; tc = 1'b0; sat = 1'b0; acc_len = 8'd4;
    send(8'hF0);
    send(8'h20);
    clr = 1'b1; bus.in_valid = 1'b1; bus.din = 8'h40;
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0;
    chk("clr.out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr.acc", 32'(bus.acc_out), 32'd0);
    chk("clr.ovf2", 32'(bus.ovf2), 32'd0);
    chk("clr.in_ready", 32'(bus.in_ready), 32'd1);
    send(8'hF0); send(8'h20); send(8'h01);
    chk("clr2.early_valid", 32'(bus.out_valid), 32'd0);
    send(8'h02);
    chk("clr2.valid", 32'(bus.out_valid), 32'd1);
    chk("clr2.acc", 32'(bus.acc_out), 32'h13);
    chk("clr2.ovf2", 32'(bus.ovf2), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rsthold.valid", 32'(bus.out_valid), 32'd0);
    chk("rsthold.acc", 32'(bus.acc_out), 32'd0);
    chk("rsthold.ovf1", 32'(bus.ovf1), 32'd0);
    chk("rsthold.ovf2", 32'(bus.ovf2), 32'd0);
    chk("rsthold.in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("rsthold.in_ready_after", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

`ifdef DW_ACCUM_DX_AVG_EN
    shamt = 4'd2;
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back(8'hF0);
    run_block("avg_shift", 1'b0, 1'b1, 1'b1, 8'd4, s, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
    shamt = 4'd0;
`endif

    // Random blocks against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      logic       dp, t, st;
      logic [7:0] len;
      int         n;
      dp  = 1'($urandom); t = 1'($urandom); st = 1'($urandom);
      len = 8'($urandom_range(0, 5));
      n   = (len == 8'd0) ? 1 : int'(len);
      s.delete();
      for (int i = 0; i < n; i++) s.push_back(8'($urandom));
      model(s, dp, t, st, ea, e1, e2);
      run_block($sformatf("rand%0d", r), dp, t, st, len, s, ea, e1, e2, 1'b1, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
